// File: rtl/fft_r2_engine.sv
// In-place radix-2 DIF FFT sequencer: walks stage/butterfly counters, drives one address
// pair per cycle and returns the butterfly results combinationally for same-cycle write-back.
module fft_r2_engine #(
    parameter int LOG2N = 10,
    parameter int DW    = 32,
    parameter int TW    = 16,
    parameter int SCALE = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Ack,
    input  logic [DW-1:0]    x_top_re,
    input  logic [DW-1:0]    x_top_im,
    input  logic [DW-1:0]    x_bot_re,
    input  logic [DW-1:0]    x_bot_im,
    output logic [LOG2N-1:0] i_top,
    output logic [LOG2N-1:0] i_bot,
    output logic [DW-1:0]    y_top_re,
    output logic [DW-1:0]    y_top_im,
    output logic [DW-1:0]    y_bot_re,
    output logic [DW-1:0]    y_bot_im,
    output logic             Done,
    output logic [3:0]       state
);

    localparam int N    = 1 << LOG2N;
    localparam int HALF = N / 2;
    localparam int BW   = LOG2N - 1;
    localparam int SW   = $clog2(LOG2N);
    localparam logic signed [DW+TW:0] RND = (DW+TW+1)'(2 ** (TW - 2));

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0100,
        ST_PROC = 4'b0010,
        ST_DONE = 4'b0001
    } state_e;

    function automatic logic signed [TW-1:0] tw_rom(input int k, input bit is_sin);
        real amp;
        real ang;
        real v;
        amp = real'((2 ** (TW - 1)) - 1);
        ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(N);
        v   = is_sin ? amp * $sin(ang) : amp * $cos(ang);
        return (v >= 0.0) ? TW'($rtoi(v + 0.5)) : TW'(-$rtoi(0.5 - v));
    endfunction

    logic signed [TW-1:0] cos_rom [HALF];
    logic signed [TW-1:0] sin_rom [HALF];

    for (genvar gk = 0; gk < HALF; gk++) begin : g_rom
        localparam logic signed [TW-1:0] C_K = tw_rom(gk, 1'b0);
        localparam logic signed [TW-1:0] S_K = tw_rom(gk, 1'b1);
        assign cos_rom[gk] = C_K;
        assign sin_rom[gk] = S_K;
    end

    state_e        state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [BW-1:0] b_q, b_d;
    logic [BW-1:0] k_q, k_d;
    logic [BW-1:0] mask_q, mask_d, j_q;
    logic [LOG2N-1:0] top_addr;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        b_d     = b_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = ST_PROC;
                    s_d     = '0;
                    b_d     = '0;
                end
            end
            ST_PROC: begin
                b_d = b_q + 1'b1;
                if (b_q == '1) begin
                    if (s_q == SW'(LOG2N - 1)) begin
                        state_d = ST_DONE;
                        s_d     = '0;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (Ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                s_d     = '0;
                b_d     = '0;
            end
        endcase

        // span-1 mask; k is registered from the next counters so it lines up with s_q/b_q
        mask_d = {BW{1'b1}} >> s_d;
        k_d    = (state_d == ST_PROC) ? ((b_d & mask_d) << s_d) : '0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            b_q     <= b_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        mask_q   = {BW{1'b1}} >> s_q;
        j_q      = b_q & mask_q;
        top_addr = {b_q & ~mask_q, 1'b0} | {1'b0, j_q};
        i_top    = '0;
        i_bot    = '0;
        if (state_q == ST_PROC) begin
            i_top = top_addr;
            i_bot = top_addr + ({1'b0, mask_q} + LOG2N'(1));
        end
    end

    logic signed [DW-1:0]    sum_re, sum_im, d_re, d_im, bot_re, bot_im;
    logic signed [TW-1:0]    c_k, s_k;
    logic signed [DW+TW-1:0] p_rc, p_is, p_ic, p_rs;
    logic signed [DW+TW:0]   acc_re, acc_im;

    always_comb begin
        sum_re = x_top_re + x_bot_re;
        sum_im = x_top_im + x_bot_im;
        d_re   = x_top_re - x_bot_re;
        d_im   = x_top_im - x_bot_im;
        c_k    = cos_rom[k_q];
        s_k    = sin_rom[k_q];
        p_rc   = (DW+TW)'(d_re) * (DW+TW)'(c_k);
        p_is   = (DW+TW)'(d_im) * (DW+TW)'(s_k);
        p_ic   = (DW+TW)'(d_im) * (DW+TW)'(c_k);
        p_rs   = (DW+TW)'(d_re) * (DW+TW)'(s_k);
        acc_re = (DW+TW+1)'(p_rc) + (DW+TW+1)'(p_is) + RND;
        acc_im = (DW+TW+1)'(p_ic) - (DW+TW+1)'(p_rs) + RND;
        if (k_q == '0) begin
            bot_re = d_re;
            bot_im = d_im;
        end else begin
            bot_re = acc_re[DW+TW-2:TW-1];
            bot_im = acc_im[DW+TW-2:TW-1];
        end
        y_top_re = (SCALE != 0) ? (sum_re >>> 1) : sum_re;
        y_top_im = (SCALE != 0) ? (sum_im >>> 1) : sum_im;
        y_bot_re = (SCALE != 0) ? (bot_re >>> 1) : bot_re;
        y_bot_im = (SCALE != 0) ? (bot_im >>> 1) : bot_im;
    end

    logic unused_acc_bits;
    assign unused_acc_bits = ^{acc_re[DW+TW:DW+TW-1], acc_re[TW-2:0],
                               acc_im[DW+TW:DW+TW-1], acc_im[TW-2:0]};

    assign Done  = (state_q == ST_DONE);
    assign state = state_q;

endmodule

// File: tb/tb_fft_r2_engine.sv
// Directed bench for fft_r2_engine: N=8 and N=1024 instances, each with a behavioural
// sample memory that commits y_* at the butterfly addresses during PROC cycles.
module tb_fft_r2_engine;

    logic clk;
    logic rst;
    logic start3, ack3, start10, ack10;

    logic [31:0] x3_top_re, x3_top_im, x3_bot_re, x3_bot_im;
    logic [31:0] y3_top_re, y3_top_im, y3_bot_re, y3_bot_im;
    logic [2:0]  i3_top, i3_bot;
    logic        done3;
    logic [3:0]  state3;

    logic [31:0] x10_top_re, x10_top_im, x10_bot_re, x10_bot_im;
    logic [31:0] y10_top_re, y10_top_im, y10_bot_re, y10_bot_im;
    logic [9:0]  i10_top, i10_bot;
    logic        done10;
    logic [3:0]  state10;

    logic signed [31:0] m3_re [8];
    logic signed [31:0] m3_im [8];
    logic signed [31:0] m10_re [1024];
    logic signed [31:0] m10_im [1024];

    int errors;
    int checks;
    int tr_top [12];
    int tr_bot [12];

    assign x3_top_re  = m3_re[i3_top];
    assign x3_top_im  = m3_im[i3_top];
    assign x3_bot_re  = m3_re[i3_bot];
    assign x3_bot_im  = m3_im[i3_bot];
    assign x10_top_re = m10_re[i10_top];
    assign x10_top_im = m10_im[i10_top];
    assign x10_bot_re = m10_re[i10_bot];
    assign x10_bot_im = m10_im[i10_bot];

    fft_r2_engine #(.LOG2N(3), .DW(32), .TW(16), .SCALE(0)) u_fft3 (
        .Clk(clk), .Reset(rst), .Start(start3), .Ack(ack3),
        .x_top_re(x3_top_re), .x_top_im(x3_top_im), .x_bot_re(x3_bot_re), .x_bot_im(x3_bot_im),
        .i_top(i3_top), .i_bot(i3_bot),
        .y_top_re(y3_top_re), .y_top_im(y3_top_im), .y_bot_re(y3_bot_re), .y_bot_im(y3_bot_im),
        .Done(done3), .state(state3)
    );

    fft_r2_engine #(.LOG2N(10), .DW(32), .TW(16), .SCALE(0)) u_fft10 (
        .Clk(clk), .Reset(rst), .Start(start10), .Ack(ack10),
        .x_top_re(x10_top_re), .x_top_im(x10_top_im), .x_bot_re(x10_bot_re), .x_bot_im(x10_bot_im),
        .i_top(i10_top), .i_bot(i10_bot),
        .y_top_re(y10_top_re), .y_top_im(y10_top_im), .y_bot_re(y10_bot_re), .y_bot_im(y10_bot_im),
        .Done(done10), .state(state10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input logic signed [63:0] obs,
                              input logic signed [63:0] exp, input int tol);
        logic ok;
        checks++;
        ok = (obs - exp <= tol) && (exp - obs <= tol);
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d +/-%0d", tag, obs, exp, tol);
        end
    endtask

    // Called at a negedge; the memory write happens mid-cycle, after the results are captured.
    task automatic run3(input bit do_start, input bit trace, output int procs, output int edges);
        logic signed [31:0] tre, tim, bre, bim;
        procs = 0;
        edges = 0;
        if (do_start) start3 = 1'b1;
        while (done3 !== 1'b1 && edges < 200) begin
            @(negedge clk);
            start3 = 1'b0;
            edges++;
            if (state3 == 4'b0010) begin
                if (trace && procs < 12) begin
                    tr_top[procs] = int'(i3_top);
                    tr_bot[procs] = int'(i3_bot);
                end
                tre = y3_top_re; tim = y3_top_im;
                bre = y3_bot_re; bim = y3_bot_im;
                m3_re[i3_top] = tre; m3_im[i3_top] = tim;
                m3_re[i3_bot] = bre; m3_im[i3_bot] = bim;
                procs++;
            end
        end
    endtask

    task automatic run10(output int procs, output int edges);
        logic signed [31:0] tre, tim, bre, bim;
        procs = 0;
        edges = 0;
        start10 = 1'b1;
        while (done10 !== 1'b1 && edges < 6000) begin
            @(negedge clk);
            start10 = 1'b0;
            edges++;
            if (state10 == 4'b0010) begin
                tre = y10_top_re; tim = y10_top_im;
                bre = y10_bot_re; bim = y10_bot_im;
                m10_re[i10_top] = tre; m10_im[i10_top] = tim;
                m10_re[i10_bot] = bre; m10_im[i10_bot] = bim;
                procs++;
            end
        end
    endtask

    initial begin
        int procs;
        int edges;
        int held;
        int exp_top [12];
        int exp_bot [12];
        int cos_in [8];
        int exp_cos [8];

        exp_top = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
        exp_bot = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
        cos_in  = '{1000, 707, 0, -707, -1000, -707, 0, 707};
        exp_cos = '{0, 0, 0, 0, 4000, 0, 0, 4000};

        errors = 0;
        checks = 0;
        rst = 1'b1;
        start3 = 1'b0; ack3 = 1'b0; start10 = 1'b0; ack10 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m3_re[i] = 0; m3_im[i] = 0;
        end
        for (int i = 0; i < 1024; i++) begin
            m10_re[i] = 0; m10_im[i] = 0;
        end
        m3_re[0] = 7;
        m3_im[0] = -3;

        // Reset state: address 0 on both ports, k=0 bypass gives x0+x0 and 0
        repeat (3) @(negedge clk);
        check("rst_state3", state3, 4'b0100);
        check("rst_done3", done3, 0);
        check("rst_itop3", i3_top, 0);
        check("rst_ibot3", i3_bot, 0);
        check("rst_ytop_re", $signed(y3_top_re), 14);
        check("rst_ytop_im", $signed(y3_top_im), -6);
        check("rst_ybot_re", $signed(y3_bot_re), 0);
        check("rst_ybot_im", $signed(y3_bot_im), 0);
        check("rst_state10", state10, 4'b0100);
        check("rst_done10", done10, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_hold3", state3, 4'b0100);

        // Impulse at N=8 with address trace
        for (int i = 0; i < 8; i++) begin
            m3_re[i] = (i == 0) ? 1000 : 0;
            m3_im[i] = 0;
        end
        run3(1'b1, 1'b1, procs, edges);
        check("imp_proc_cycles", procs, 12);
        check("imp_edges_to_done", edges, 13);
        check("imp_done", done3, 1);
        check("imp_state_done", state3, 4'b0001);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("trace%0d_top", i), tr_top[i], exp_top[i]);
            check($sformatf("trace%0d_bot", i), tr_bot[i], exp_bot[i]);
        end
        for (int i = 0; i < 8; i++) begin
            check($sformatf("imp_bin%0d_re", i), m3_re[i], 1000);
            check($sformatf("imp_bin%0d_im", i), m3_im[i], 0);
        end
        check("done_itop", i3_top, 0);
        check("done_ibot", i3_bot, 0);

        // DONE persists without Ack, then an Ack pulse releases it
        held = 0;
        repeat (100) begin
            @(negedge clk);
            if (done3 === 1'b1 && state3 === 4'b0001) held++;
        end
        check("done_held_100", held, 100);
        ack3 = 1'b1;
        @(negedge clk);
        ack3 = 1'b0;
        check("ack_state_idle", state3, 4'b0100);
        check("ack_done_low", done3, 0);

        // Cosine at bin 1: energy lands at bit-reversed addresses 4 and 7
        for (int i = 0; i < 8; i++) begin
            m3_re[i] = cos_in[i];
            m3_im[i] = 0;
        end
        run3(1'b1, 1'b0, procs, edges);
        check("cos_proc_cycles", procs, 12);
        check("cos_done", done3, 1);
        for (int i = 0; i < 8; i++) begin
            check_near($sformatf("cos_addr%0d_re", i), m3_re[i], exp_cos[i], 2);
            check_near($sformatf("cos_addr%0d_im", i), m3_im[i], 0, 2);
        end

        // Start and Ack together in DONE: IDLE only, no immediate restart
        start3 = 1'b1;
        ack3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        ack3 = 1'b0;
        check("startack_state", state3, 4'b0100);
        check("startack_done", done3, 0);
        @(negedge clk);
        check("startack_stays_idle", state3, 4'b0100);

        // Start during PROC ignored; Reset at PROC cycle 7 aborts; fresh Start restarts
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        check("p1_state", state3, 4'b0010);
        check("p1_itop", i3_top, 0);
        check("p1_ibot", i3_bot, 4);
        @(negedge clk);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        check("p3_state", state3, 4'b0010);
        check("p3_itop", i3_top, 2);
        check("p3_ibot", i3_bot, 6);
        repeat (4) @(negedge clk);
        check("p7_itop", i3_top, 4);
        check("p7_ibot", i3_bot, 6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_state", state3, 4'b0100);
        check("abort_done", done3, 0);
        check("abort_itop", i3_top, 0);
        check("abort_ibot", i3_bot, 0);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        check("restart_state", state3, 4'b0010);
        check("restart_itop", i3_top, 0);
        check("restart_ibot", i3_bot, 4);
        run3(1'b0, 1'b0, procs, edges);
        check("restart_rest_cycles", procs, 11);
        check("restart_done", done3, 1);
        ack3 = 1'b1;
        @(negedge clk);
        ack3 = 1'b0;

        // Constant input at N=1024: only bin 0, exact through the bypass path
        for (int i = 0; i < 1024; i++) begin
            m10_re[i] = 1;
            m10_im[i] = 0;
        end
        run10(procs, edges);
        check("n1024_proc_cycles", procs, 5120);
        check("n1024_edges_to_done", edges, 5121);
        check("n1024_done", done10, 1);
        check("n1024_bin0_re", m10_re[0], 1024);
        check("n1024_bin0_im", m10_im[0], 0);
        for (int i = 1; i < 1024; i++) begin
            check($sformatf("n1024_addr%0d_re", i), m10_re[i], 0);
            check($sformatf("n1024_addr%0d_im", i), m10_im[i], 0);
        end
        ack10 = 1'b1;
        @(negedge clk);
        ack10 = 1'b0;
        check("n1024_ack_idle", state10, 4'b0100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
